// File: rtl/periph_slave_arbiter.sv
// Round-robin arbiter sharing one peripheral slave port among N_MASTER masters.
// One transaction is outstanding at a time. The response is routed back to the
// owner only, and a watchdog answers with an error if the slave stays silent.
module periph_slave_arbiter #(
  parameter int                    N_MASTER   = 8,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    BE_WIDTH   = DATA_WIDTH / 8,
  parameter int                    LOG_MASTER = $clog2(N_MASTER),
  parameter int                    TIMEOUT    = 255,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA   = DATA_WIDTH'(32'hBADACCE5)
) (
  input  logic                           clk,
  input  logic                           rst,
  // master side
  input  logic [N_MASTER-1:0]            data_req_i,
  input  logic [N_MASTER*ADDR_WIDTH-1:0] data_add_i,
  input  logic [N_MASTER-1:0]            data_wen_i,
  input  logic [N_MASTER*DATA_WIDTH-1:0] data_wdata_i,
  input  logic [N_MASTER*BE_WIDTH-1:0]   data_be_i,
  output logic [N_MASTER-1:0]            data_gnt_o,
  output logic [N_MASTER-1:0]            data_r_valid_o,
  output logic [DATA_WIDTH-1:0]          data_r_rdata_o,
  output logic                           data_r_opc_o,
  // slave side
  output logic                           data_req_o,
  output logic [ADDR_WIDTH-1:0]          data_add_o,
  output logic                           data_wen_o,
  output logic [DATA_WIDTH-1:0]          data_wdata_o,
  output logic [BE_WIDTH-1:0]            data_be_o,
  output logic [LOG_MASTER-1:0]          data_ID_o,
  input  logic                           data_gnt_i,
  input  logic                           data_r_valid_i,
  input  logic [DATA_WIDTH-1:0]          data_r_rdata_i,
  input  logic                           data_r_opc_i,
  // status
  output logic                           timeout_o,
  output logic [7:0]                     drop_cnt_o
);

  typedef enum logic {
    S_IDLE      = 1'b0,
    S_WAIT_RESP = 1'b1
  } state_t;

  // Watchdog value in the last WAIT_RESP cycle before the error response.
  localparam logic [15:0]           WDOG_LAST   = 16'(TIMEOUT - 1);
  localparam logic [LOG_MASTER-1:0] LAST_MASTER = LOG_MASTER'(N_MASTER - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [LOG_MASTER-1:0] r_rr_ptr;
  logic [LOG_MASTER-1:0] r_owner;
  logic [15:0]           r_wdog;
  logic [N_MASTER-1:0]   r_r_valid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_opc;
  logic                  r_timeout;
  logic [7:0]            r_drop;

  logic [LOG_MASTER:0]   w_pick;
  logic                  w_found;
  logic [LOG_MASTER-1:0] w_winner;
  logic                  w_hs;
  logic                  w_expire;

  // First requester at or after ptr, wrapping modulo N_MASTER; MSB flags a hit.
  function automatic logic [LOG_MASTER:0] f_pick(input logic [N_MASTER-1:0]   req,
                                                 input logic [LOG_MASTER-1:0] ptr);
    logic                  found;
    logic [LOG_MASTER-1:0] idx;
    logic [LOG_MASTER:0]   pos;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N_MASTER; k++) begin
      pos = {1'b0, ptr} + (LOG_MASTER + 1)'(k);
      if (pos >= (LOG_MASTER + 1)'(N_MASTER)) pos = pos - (LOG_MASTER + 1)'(N_MASTER);
      if (!found && req[pos[LOG_MASTER-1:0]]) begin
        found = 1'b1;
        idx   = pos[LOG_MASTER-1:0];
      end
    end
    return {found, idx};
  endfunction

  assign w_pick   = f_pick(data_req_i, r_rr_ptr);
  assign w_found  = w_pick[LOG_MASTER];
  assign w_winner = w_pick[LOG_MASTER-1:0];

  // A real response in the expiry cycle takes precedence over the error.
  assign w_expire = (r_state == S_WAIT_RESP) && !data_r_valid_i && (r_wdog == WDOG_LAST);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block evaluation order.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state, slave-side payload mux and same-cycle grant return.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned
    // and no latch is inferred.
    w_state_nxt  = r_state;
    w_hs         = 1'b0;
    data_req_o   = 1'b0;
    data_add_o   = '0;
    data_wen_o   = 1'b0;
    data_wdata_o = '0;
    data_be_o    = '0;
    data_ID_o    = r_owner;
    data_gnt_o   = '0;
    case (r_state)
      S_IDLE: begin
        data_ID_o  = w_winner;
        data_req_o = w_found;
        if (w_found) begin
          data_add_o             = data_add_i[int'(w_winner)*ADDR_WIDTH +: ADDR_WIDTH];
          data_wen_o             = data_wen_i[w_winner];
          data_wdata_o           = data_wdata_i[int'(w_winner)*DATA_WIDTH +: DATA_WIDTH];
          data_be_o              = data_be_i[int'(w_winner)*BE_WIDTH +: BE_WIDTH];
          data_gnt_o[w_winner]   = data_gnt_i;
          if (data_gnt_i) begin
            w_hs        = 1'b1;
            w_state_nxt = S_WAIT_RESP;
          end
        end
      end
      S_WAIT_RESP: begin
        if (data_r_valid_i || w_expire) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Pointer/owner/watchdog bookkeeping, registered response and drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr  <= '0;
      r_owner   <= '0;
      r_wdog    <= '0;
      r_r_valid <= '0;
      r_rdata   <= '0;
      r_opc     <= 1'b0;
      r_timeout <= 1'b0;
      r_drop    <= '0;
    end else begin
      r_r_valid <= '0;
      r_timeout <= 1'b0;
      if (w_hs) begin
        r_owner  <= w_winner;
        r_rr_ptr <= (w_winner == LAST_MASTER) ? '0 : w_winner + 1'b1;
        r_wdog   <= '0;
      end else if (r_state == S_WAIT_RESP) begin
        r_wdog <= r_wdog + 16'd1;
      end
      if (r_state == S_WAIT_RESP && data_r_valid_i) begin
        r_r_valid[r_owner] <= 1'b1;
        r_rdata            <= data_r_rdata_i;
        r_opc              <= data_r_opc_i;
      end else if (w_expire) begin
        r_r_valid[r_owner] <= 1'b1;
        r_rdata            <= ERR_DATA;
        r_opc              <= 1'b1;
        r_timeout          <= 1'b1;
      end
      // Responses with no transaction outstanding are dropped and counted.
      if (r_state == S_IDLE && data_r_valid_i && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
    end
  end

  assign data_r_valid_o = r_r_valid;
  assign data_r_rdata_o = r_rdata;
  assign data_r_opc_o   = r_opc;
  assign timeout_o      = r_timeout;
  assign drop_cnt_o     = r_drop;

endmodule
